// File: rtl/avalon_mm_arb_pkg.sv
// Shared types and the round-robin pick helper for the Avalon-MM arbiter.
package avalon_mm_arb_pkg;

  localparam int MAX_MASTERS = 8;

  typedef logic [2:0] master_id_t;

  typedef struct packed {
    logic       vld;
    master_id_t id;
  } rr_pick_t;

  // First set bit of req at or after ptr, wrapping. Bits above the real
  // master count must be zero, so wrapping modulo MAX_MASTERS lands on the
  // same winner as wrapping modulo the real count. ptr = 0 yields plain
  // lowest-index priority.
  function automatic rr_pick_t rr_pick(input logic [MAX_MASTERS-1:0] req,
                                       input master_id_t              ptr);
    rr_pick_t   r;
    master_id_t idx;
    r = '0;
    // Walk farthest-to-nearest so the nearest hit overwrites the others.
    for (int k = MAX_MASTERS - 1; k >= 0; k--) begin
      idx = ptr + master_id_t'(k);
      if (req[idx]) begin
        r.vld = 1'b1;
        r.id  = idx;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/avalon_mm_arb_id_fifo.sv
// In-order FIFO of master IDs for outstanding reads. DEPTH must be a power
// of two; the extra pointer bit separates full from empty.
module avalon_mm_arb_id_fifo
  import avalon_mm_arb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  master_id_t din,
  output master_id_t dout,
  output logic       full,
  output logic       empty
);

  localparam int PW = $clog2(DEPTH);

  master_id_t    mem [DEPTH];
  logic [PW:0]   wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign dout    = mem[rd_ptr[PW-1:0]];

  // Pointer update; reset forgets every outstanding entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{PW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{PW{1'b0}}, 1'b1};
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/avalon_mm_arbiter.sv
// N-to-1 Avalon-MM arbiter with in-order read response routing.
// Build option: define AVMM_ARB_FIXED_PRIO_EN for fixed lowest-index
// priority (no rotating pointer); default is round-robin.
module avalon_mm_arbiter
  import avalon_mm_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MAX_PENDING = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] m_address,
  input  logic [NUM_MASTERS-1:0]                 m_read,
  input  logic [NUM_MASTERS-1:0]                 m_write,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_writedata,
  output logic [NUM_MASTERS-1:0]                 m_waitrequest,
  output logic [DATA_WIDTH-1:0]                  m_readdata,
  output logic [NUM_MASTERS-1:0]                 m_readdatavalid,
  output logic [ADDR_WIDTH-1:0]                  s_address,
  output logic                                   s_read,
  output logic                                   s_write,
  output logic [DATA_WIDTH-1:0]                  s_writedata,
  input  logic [DATA_WIDTH-1:0]                  s_readdata,
  input  logic                                   s_readdatavalid,
  output logic                                   orphan_err
);

  logic [NUM_MASTERS-1:0] rd_req, wr_req, elig, gnt, rsp_oh;
  logic [MAX_MASTERS-1:0] req_pad;
  rr_pick_t               pick;
  logic                   fifo_full, fifo_empty, push, pop;
  master_id_t             head_id;
  logic                   win_rd, win_wr;
  logic [ADDR_WIDTH-1:0]  win_addr;
  logic [DATA_WIDTH-1:0]  win_wdata;

  // Per-master request decode. Write beats read when both strobes are up;
  // reads are held off while the pending FIFO is full, even if a response
  // drains it this same cycle. Grants are suppressed while in reset.
  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_lane
    assign wr_req[i] = m_write[i];
    assign rd_req[i] = m_read[i] & ~m_write[i];
    assign elig[i]   = wr_req[i] | (rd_req[i] & ~fifo_full);
    assign gnt[i]    = rst_n & pick.vld & (pick.id == master_id_t'(i));
    assign rsp_oh[i] = pop & (head_id == master_id_t'(i));
  end

  assign m_waitrequest = ~gnt;
  assign push          = win_rd;
  assign pop           = s_readdatavalid & ~fifo_empty;

  // Widen the eligible set to the helper's fixed width; upper bits stay zero.
  always_comb begin
    req_pad                  = '0;
    req_pad[NUM_MASTERS-1:0] = elig;
  end

`ifdef AVMM_ARB_FIXED_PRIO_EN
  assign pick = rr_pick(req_pad, master_id_t'(0));
`else
  master_id_t rr_ptr;

  assign pick = rr_pick(req_pad, rr_ptr);

  // Rotate the search start to just past the last winner; hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_ptr <= '0;
    else if (|gnt)
      rr_ptr <= (pick.id == master_id_t'(NUM_MASTERS - 1)) ? '0 : pick.id + 3'd1;
  end
`endif

  // One-hot mux of the winning master's command.
  always_comb begin
    win_rd    = 1'b0;
    win_wr    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt[i]) begin
        win_rd    = rd_req[i];
        win_wr    = wr_req[i];
        win_addr  = m_address[i];
        win_wdata = m_writedata[i];
      end
    end
  end

  // Register the accepted command downstream; address/data hold when idle,
  // write data only changes on writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_read      <= 1'b0;
      s_write     <= 1'b0;
      s_address   <= '0;
      s_writedata <= '0;
    end else begin
      s_read  <= win_rd;
      s_write <= win_wr;
      if (win_rd || win_wr) s_address   <= win_addr;
      if (win_wr)           s_writedata <= win_wdata;
    end
  end

  // Route each response to the head-of-FIFO master; flag responses that
  // arrive with nothing outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_readdatavalid <= '0;
      m_readdata      <= '0;
      orphan_err      <= 1'b0;
    end else begin
      m_readdatavalid <= rsp_oh;
      if (pop) m_readdata <= s_readdata;
      if (s_readdatavalid && fifo_empty) orphan_err <= 1'b1;
    end
  end

  avalon_mm_arb_id_fifo #(
    .DEPTH (MAX_PENDING)
  ) u_id_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (pick.id),
    .dout  (head_id),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// Self-checking bench for avalon_mm_arbiter: directed scenarios plus a
// randomized run checked against a queue-based reference model.
module tb_avalon_mm_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MP = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N-1:0][AW-1:0] m_address;
  logic [N-1:0]         m_read, m_write;
  logic [N-1:0][DW-1:0] m_writedata;
  logic [N-1:0]         m_waitrequest;
  logic [DW-1:0]        m_readdata;
  logic [N-1:0]         m_readdatavalid;
  logic [AW-1:0]        s_address;
  logic                 s_read, s_write;
  logic [DW-1:0]        s_writedata;
  logic [DW-1:0]        s_readdata;
  logic                 s_readdatavalid;
  logic                 orphan_err;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  avalon_mm_arbiter #(
    .NUM_MASTERS (N),
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .MAX_PENDING (MP)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .m_address       (m_address),
    .m_read          (m_read),
    .m_write         (m_write),
    .m_writedata     (m_writedata),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid),
    .s_address       (s_address),
    .s_read          (s_read),
    .s_write         (s_write),
    .s_writedata     (s_writedata),
    .s_readdata      (s_readdata),
    .s_readdatavalid (s_readdatavalid),
    .orphan_err      (orphan_err)
  );

  task automatic clear_inputs();
    m_read = '0; m_write = '0; m_address = '0; m_writedata = '0;
    s_readdatavalid = 1'b0; s_readdata = '0;
  endtask

  // Leaves the bench just after a negedge with the DUT out of reset.
  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    m_write = '1; m_read = '1;
    @(posedge clk); #1;
    vecs++; if (m_waitrequest !== 4'hF) begin errs++; $display("FAIL rst_wait got=%b exp=1111", m_waitrequest); end
    vecs++; if ({s_read, s_write, orphan_err} !== 3'b000) begin errs++; $display("FAIL rst_strobes got=%b exp=000", {s_read, s_write, orphan_err}); end
    vecs++; if (m_readdatavalid !== 4'h0) begin errs++; $display("FAIL rst_rdv got=%b exp=0000", m_readdatavalid); end
    vecs++; if (s_address !== '0 || s_writedata !== '0 || m_readdata !== '0) begin errs++; $display("FAIL rst_data got=%h/%h/%h exp=0", s_address, s_writedata, m_readdata); end
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    @(negedge clk); #1;
    vecs++; if (m_waitrequest !== 4'hF) begin errs++; $display("FAIL idle_wait got=%b exp=1111", m_waitrequest); end
    @(posedge clk); #1;
    vecs++; if (s_read !== 1'b0 || s_write !== 1'b0) begin errs++; $display("FAIL idle_cmd got=%b%b exp=00", s_read, s_write); end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int exp;
    do_reset();
    for (int i = 0; i < N; i++) begin
      m_address[i]   = 32'h1000 + i;
      m_writedata[i] = 32'hD0 + i;
    end
    m_write = 4'hF;
    for (int k = 0; k < 5; k++) begin
`ifdef AVMM_ARB_FIXED_PRIO_EN
      exp = 0;
`else
      exp = k % N;
`endif
      #1;
      vecs++; if (m_waitrequest !== ~(4'b0001 << exp)) begin errs++; $display("FAIL rr_wait k=%0d got=%b exp=%b", k, m_waitrequest, ~(4'b0001 << exp)); end
      @(posedge clk); #1;
      vecs++; if (s_write !== 1'b1 || s_read !== 1'b0) begin errs++; $display("FAIL rr_swrite k=%0d got=%b%b exp=01", k, s_read, s_write); end
      vecs++; if (s_address !== 32'h1000 + exp || s_writedata !== 32'hD0 + exp) begin errs++; $display("FAIL rr_addr k=%0d got=%h/%h exp=%h/%h", k, s_address, s_writedata, 32'h1000 + exp, 32'hD0 + exp); end
      @(negedge clk);
    end
    m_write = '0;
    @(posedge clk); #1;
    vecs++; if (s_write !== 1'b0) begin errs++; $display("FAIL rr_stop got=%b exp=0", s_write); end
    @(negedge clk);
  endtask

  task automatic test_read_routing();
    do_reset();
    m_read[2] = 1'b1; m_address[2] = 32'h10;
    #1;
    vecs++; if (m_waitrequest !== 4'b1011) begin errs++; $display("FAIL rd_wait2 got=%b exp=1011", m_waitrequest); end
    @(posedge clk); #1;
    vecs++; if (s_read !== 1'b1 || s_address !== 32'h10) begin errs++; $display("FAIL rd_cmd2 got=%b/%h exp=1/10", s_read, s_address); end
    @(negedge clk);
    m_read = '0; m_read[1] = 1'b1; m_address[1] = 32'h20;
    #1;
    vecs++; if (m_waitrequest !== 4'b1101) begin errs++; $display("FAIL rd_wait1 got=%b exp=1101", m_waitrequest); end
    @(posedge clk); #1;
    vecs++; if (s_read !== 1'b1 || s_address !== 32'h20) begin errs++; $display("FAIL rd_cmd1 got=%b/%h exp=1/20", s_read, s_address); end
    @(negedge clk);
    m_read = '0;
    s_readdatavalid = 1'b1; s_readdata = 32'hAAAA;
    @(posedge clk); #1;
    vecs++; if (m_readdatavalid !== 4'b0100 || m_readdata !== 32'hAAAA) begin errs++; $display("FAIL rd_rsp2 got=%b/%h exp=0100/aaaa", m_readdatavalid, m_readdata); end
    @(negedge clk);
    s_readdata = 32'h5555;
    @(posedge clk); #1;
    vecs++; if (m_readdatavalid !== 4'b0010 || m_readdata !== 32'h5555) begin errs++; $display("FAIL rd_rsp1 got=%b/%h exp=0010/5555", m_readdatavalid, m_readdata); end
    @(negedge clk);
    s_readdatavalid = 1'b0; s_readdata = 32'h1234;
    @(posedge clk); #1;
    vecs++; if (m_readdatavalid !== 4'b0000 || m_readdata !== 32'h5555 || orphan_err !== 1'b0) begin errs++; $display("FAIL rd_hold got=%b/%h/%b exp=0000/5555/0", m_readdatavalid, m_readdata, orphan_err); end
    @(negedge clk);
  endtask

  task automatic test_fifo_full();
    do_reset();
    m_read[0] = 1'b1;
    for (int k = 0; k < MP; k++) begin
      m_address[0] = 32'h100 + k;
      #1;
      vecs++; if (m_waitrequest !== 4'b1110) begin errs++; $display("FAIL full_fill k=%0d got=%b exp=1110", k, m_waitrequest); end
      @(posedge clk);
      @(negedge clk);
    end
    m_address[0] = 32'h108;
    m_write[3] = 1'b1; m_address[3] = 32'h3000; m_writedata[3] = 32'h33;
    #1;
    vecs++; if (m_waitrequest !== 4'b0111) begin errs++; $display("FAIL full_wr_wait got=%b exp=0111", m_waitrequest); end
    @(posedge clk); #1;
    vecs++; if (s_write !== 1'b1 || s_read !== 1'b0 || s_address !== 32'h3000 || s_writedata !== 32'h33) begin errs++; $display("FAIL full_wr_cmd got=%b%b/%h/%h exp=01/3000/33", s_read, s_write, s_address, s_writedata); end
    @(negedge clk);
    m_write[3] = 1'b0;
    s_readdatavalid = 1'b1; s_readdata = 32'h77;
    #1;
    vecs++; if (m_waitrequest !== 4'b1111) begin errs++; $display("FAIL full_pop_wait got=%b exp=1111", m_waitrequest); end
    @(posedge clk); #1;
    vecs++; if (m_readdatavalid !== 4'b0001 || m_readdata !== 32'h77 || s_read !== 1'b0) begin errs++; $display("FAIL full_pop_rsp got=%b/%h/%b exp=0001/77/0", m_readdatavalid, m_readdata, s_read); end
    @(negedge clk);
    s_readdatavalid = 1'b0;
    #1;
    vecs++; if (m_waitrequest !== 4'b1110) begin errs++; $display("FAIL full_regrant got=%b exp=1110", m_waitrequest); end
    @(posedge clk); #1;
    vecs++; if (s_read !== 1'b1 || s_address !== 32'h108) begin errs++; $display("FAIL full_regrant_cmd got=%b/%h exp=1/108", s_read, s_address); end
    @(negedge clk);
    m_read = '0;
  endtask

  task automatic test_orphan();
    do_reset();
    s_readdatavalid = 1'b1; s_readdata = 32'hBEEF;
    @(posedge clk); #1;
    vecs++; if (orphan_err !== 1'b1 || m_readdatavalid !== 4'b0000 || m_readdata !== '0) begin errs++; $display("FAIL orphan got=%b/%b/%h exp=1/0000/0", orphan_err, m_readdatavalid, m_readdata); end
    @(negedge clk);
    s_readdatavalid = 1'b0;
    repeat (2) @(posedge clk); #1;
    vecs++; if (orphan_err !== 1'b1) begin errs++; $display("FAIL orphan_sticky got=%b exp=1", orphan_err); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      m_read = '0; m_read[k] = 1'b1; m_address[k] = 32'h40 + k;
      @(posedge clk);
      @(negedge clk);
    end
    m_read = '0;
    rst_n = 1'b0;
    #1;
    vecs++; if (m_waitrequest !== 4'hF || s_read !== 1'b0 || s_write !== 1'b0) begin errs++; $display("FAIL mid_rst_cmd got=%b/%b%b exp=1111/00", m_waitrequest, s_read, s_write); end
    vecs++; if (s_address !== '0 || m_readdatavalid !== '0 || orphan_err !== 1'b0 || m_readdata !== '0) begin errs++; $display("FAIL mid_rst_state got=%h/%b/%b/%h exp=0", s_address, m_readdatavalid, orphan_err, m_readdata); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    s_readdatavalid = 1'b1; s_readdata = 32'h99;
    @(posedge clk); #1;
    vecs++; if (orphan_err !== 1'b1 || m_readdatavalid !== 4'b0000) begin errs++; $display("FAIL mid_rst_late got=%b/%b exp=1/0000", orphan_err, m_readdatavalid); end
    @(negedge clk);
    s_readdatavalid = 1'b0;
  endtask

  task automatic test_two_masters();
    int exp;
    do_reset();
    m_address[0] = 32'hA0; m_address[3] = 32'hA3;
    m_write[0] = 1'b1; m_write[3] = 1'b1;
    for (int k = 0; k < 6; k++) begin
`ifdef AVMM_ARB_FIXED_PRIO_EN
      exp = 0;
`else
      exp = (k % 2 == 0) ? 0 : 3;
`endif
      #1;
      vecs++; if (m_waitrequest !== ~(4'b0001 << exp)) begin errs++; $display("FAIL prio_wait k=%0d got=%b exp=%b", k, m_waitrequest, ~(4'b0001 << exp)); end
      @(posedge clk); #1;
      vecs++; if (s_write !== 1'b1 || s_address !== 32'hA0 + exp) begin errs++; $display("FAIL prio_cmd k=%0d got=%b/%h exp=1/%h", k, s_write, s_address, 32'hA0 + exp); end
      @(negedge clk);
    end
    m_write = '0;
  endtask

  // Reference model: integer search pointer plus a queue of issuing IDs.
  task automatic test_random();
    int            rr, w, idx;
    int            q[$];
    logic [N-1:0]  rd, wr, exp_wait, exp_rdv;
    logic          rdv, exp_sr, exp_sw;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd, exp_rdata;
    do_reset();
    rr = 0; exp_addr = '0; exp_wd = '0; exp_rdata = '0;
    for (int c = 0; c < 500; c++) begin
      rd = 4'($urandom);
      wr = 4'($urandom) & 4'($urandom) & 4'($urandom);
      for (int i = 0; i < N; i++) begin
        m_address[i]   = $urandom;
        m_writedata[i] = $urandom;
      end
      rdv = (q.size() > 0) && ($urandom_range(0, 99) < 35);
      m_read = rd; m_write = wr;
      s_readdatavalid = rdv; s_readdata = $urandom;

      w = -1;
      for (int k = 0; k < N; k++) begin
        idx = (rr + k) % N;
        if (w < 0 && (wr[idx] || (rd[idx] && q.size() < MP))) w = idx;
      end
      exp_wait = '1;
      if (w >= 0) exp_wait[w] = 1'b0;
      #1;
      vecs++; if (m_waitrequest !== exp_wait) begin errs++; $display("FAIL rnd_wait c=%0d got=%b exp=%b", c, m_waitrequest, exp_wait); end

      exp_sr = 1'b0; exp_sw = 1'b0;
      if (w >= 0) begin
        exp_sw   = wr[w];
        exp_sr   = !wr[w];
        exp_addr = m_address[w];
        if (wr[w]) exp_wd = m_writedata[w];
      end
      exp_rdv = '0;
      if (rdv) begin
        exp_rdv[q[0]] = 1'b1;
        exp_rdata     = s_readdata;
        q.delete(0);
      end
      if (exp_sr) q.push_back(w);
`ifndef AVMM_ARB_FIXED_PRIO_EN
      if (w >= 0) rr = (w + 1) % N;
`endif

      @(posedge clk); #1;
      vecs++; if (s_read !== exp_sr || s_write !== exp_sw) begin errs++; $display("FAIL rnd_cmd c=%0d got=%b%b exp=%b%b", c, s_read, s_write, exp_sr, exp_sw); end
      vecs++; if (s_address !== exp_addr) begin errs++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, s_address, exp_addr); end
      vecs++; if (s_writedata !== exp_wd) begin errs++; $display("FAIL rnd_wdata c=%0d got=%h exp=%h", c, s_writedata, exp_wd); end
      vecs++; if (m_readdatavalid !== exp_rdv) begin errs++; $display("FAIL rnd_rdv c=%0d got=%b exp=%b", c, m_readdatavalid, exp_rdv); end
      vecs++; if (m_readdata !== exp_rdata) begin errs++; $display("FAIL rnd_rdata c=%0d got=%h exp=%h", c, m_readdata, exp_rdata); end
      vecs++; if (orphan_err !== 1'b0) begin errs++; $display("FAIL rnd_orphan c=%0d got=%b exp=0", c, orphan_err); end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_round_robin();
    test_read_routing();
    test_fifo_full();
    test_orphan();
    test_reset_mid_read();
    test_two_masters();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
